// File: rtl/atomik_pll_pkg.sv
// Shared definitions for the fabric PLL feedback-divider sequencer.
//   pll_state_e    : sequencer states
//   mult_to_fbdsel : multiplier to PLL FBDSEL pin encoding (64 - mult)
//   MULT_MIN_DEF / MULT_MAX_DEF : default accepted multiplier range
package atomik_pll_pkg;

  localparam int unsigned MULT_MIN_DEF = 8;   // VCO stays >= 432 MHz
  localparam int unsigned MULT_MAX_DEF = 16;

  typedef enum logic [2:0] {
    ST_APPLY,
    ST_HOLD,
    ST_WAIT_LOCK,
    ST_SETTLE,
    ST_IDLE,
    ST_FAIL
  } pll_state_e;

  function automatic logic [5:0] mult_to_fbdsel(input logic [5:0] mult);
    return 6'(7'd64 - {1'b0, mult});
  endfunction

endpackage

// File: rtl/atomik_pll_ctrl_if.sv
// Multiplier-change request channel of the PLL sequencer.
//   req_valid  : request strobe (requester -> sequencer)
//   req_mult   : requested multiplier (requester -> sequencer)
//   req_ready  : sequencer can take a request (IDLE/FAIL)
//   req_reject : one-cycle pulse, request out of range and dropped
interface atomik_pll_ctrl_if;
  logic       req_valid;
  logic [5:0] req_mult;
  logic       req_ready;
  logic       req_reject;

  modport master (output req_valid, req_mult, input  req_ready, req_reject);
  modport slave  (input  req_valid, req_mult, output req_ready, req_reject);
endinterface

// File: rtl/atomik_sync2.sv
// Generic two-flop synchronizer, synchronous active-low reset to 0.
//   clk, rst_n : destination clock and reset
//   d          : asynchronous input
//   q          : synchronized output (2 cycles latency)
module atomik_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/atomik_pll_ctrl.sv
// Sequencer for the dynamic feedback divider of the 108 MHz fabric PLL.
// Runs on the 27 MHz reference clock; brings the PLL up with DEFAULT_MULT,
// applies multiplier-change requests (divider only changes while the PLL is
// held in reset), qualifies lock and reports clk_ok to the clkout domain.
// Ports:
//   clk, rst_n   : reference clock, synchronous active-low reset
//   req          : request channel (atomik_pll_ctrl_if.slave)
//   pll_fbdsel   : PLL FBDSEL pins (64 - mult)
//   pll_reset    : PLL RESET, active-high
//   pll_lock     : PLL LOCK, asynchronous
//   clk_ok       : clkout stable at cur_mult
//   busy         : sequence in progress
//   fail         : sticky, last request exhausted its retries
//   lock_lost    : sticky, lock dropped in IDLE; cleared on accepted request
//   cur_mult     : multiplier currently programmed
// Optional feature: define ATOMIK_PLL_AUTORELOCK_EN to re-run the reset/lock
// sequence automatically when lock drops in IDLE.
module atomik_pll_ctrl
  import atomik_pll_pkg::*;
#(
  parameter int unsigned DEFAULT_MULT        = 8,
  parameter int unsigned MULT_MIN            = MULT_MIN_DEF,
  parameter int unsigned MULT_MAX            = MULT_MAX_DEF,
  parameter int unsigned RESET_HOLD_CYCLES   = 16,
  parameter int unsigned SETTLE_CYCLES       = 256,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65535,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  atomik_pll_ctrl_if.slave        req,
  output logic [5:0]              pll_fbdsel,
  output logic                    pll_reset,
  input  logic                    pll_lock,
  output logic                    clk_ok,
  output logic                    busy,
  output logic                    fail,
  output logic                    lock_lost,
  output logic [5:0]              cur_mult
);

  localparam int unsigned HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);
  localparam int unsigned TO_W   = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int unsigned SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned RTY_W  = $clog2(MAX_RETRIES + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [RTY_W-1:0]  RTY_LAST  = RTY_W'(MAX_RETRIES - 1);
  localparam logic [5:0]        MIN6      = 6'(MULT_MIN);
  localparam logic [5:0]        MAX6      = 6'(MULT_MAX);
  localparam logic [5:0]        DEF6      = 6'(DEFAULT_MULT);

  pll_state_e        state_d, state_q;
  logic [HOLD_W-1:0] hold_cnt_d, hold_cnt_q;
  logic [TO_W-1:0]   to_cnt_d, to_cnt_q;
  logic [SET_W-1:0]  settle_cnt_d, settle_cnt_q;
  logic [RTY_W-1:0]  retry_d, retry_q;
  logic [5:0]        pend_mult_d, pend_mult_q;
  logic [5:0]        cur_mult_d, cur_mult_q;
  logic [5:0]        fbdsel_d, fbdsel_q;
  logic              pll_reset_d, pll_reset_q;
  logic              clk_ok_d, clk_ok_q;
  logic              busy_d, busy_q;
  logic              fail_d, fail_q;
  logic              lock_lost_d, lock_lost_q;
  logic              req_reject_d, req_reject_q;

  logic lock_s;
  logic req_ready_w;
  logic req_in_range;

  atomik_sync2 #(.WIDTH(1)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  assign req_ready_w  = (state_q == ST_IDLE) || (state_q == ST_FAIL);
  assign req_in_range = (req.req_mult >= MIN6) && (req.req_mult <= MAX6);

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    to_cnt_d     = to_cnt_q;
    settle_cnt_d = settle_cnt_q;
    retry_d      = retry_q;
    pend_mult_d  = pend_mult_q;
    cur_mult_d   = cur_mult_q;
    clk_ok_d     = clk_ok_q;
    fail_d       = fail_q;
    lock_lost_d  = lock_lost_q;
    req_reject_d = 1'b0;

    unique case (state_q)
      ST_APPLY: begin
        // Divider is latched only once the PLL has been in reset a cycle.
        state_d    = ST_HOLD;
        hold_cnt_d = '0;
        cur_mult_d = pend_mult_q;
      end

      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d      = ST_WAIT_LOCK;
          to_cnt_d     = '0;
          settle_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      ST_WAIT_LOCK: begin
        if (lock_s) begin
          // This cycle is the first of the settle run.
          state_d      = ST_SETTLE;
          settle_cnt_d = SET_W'(1);
        end else if (to_cnt_q == TO_LAST) begin
          retry_d = retry_q + 1'b1;
          if (retry_q == RTY_LAST) begin
            state_d = ST_FAIL;
            fail_d  = 1'b1;
          end else begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
          end
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      ST_SETTLE: begin
        // Timeout counter is frozen here so glitchy lock cannot extend the attempt.
        if (!lock_s) begin
          state_d      = ST_WAIT_LOCK;
          settle_cnt_d = '0;
        end else if (settle_cnt_q == SET_LAST) begin
          state_d  = ST_IDLE;
          clk_ok_d = 1'b1;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end

      ST_IDLE: begin
        if (!lock_s) begin
          clk_ok_d     = 1'b0;
          lock_lost_d  = 1'b1;
          settle_cnt_d = '0;
`ifdef ATOMIK_PLL_AUTORELOCK_EN
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
          retry_d    = '0;
`endif
        end else if (!clk_ok_q) begin
          // Re-qualify lock in place: clk_ok needs a full unbroken settle run.
          if (settle_cnt_q == SET_LAST) begin
            clk_ok_d = 1'b1;
          end else begin
            settle_cnt_d = settle_cnt_q + 1'b1;
          end
        end
      end

      ST_FAIL: ;

      default: state_d = ST_HOLD;
    endcase

    // Request acceptance overrides IDLE lock monitoring.
    if (req.req_valid && req_ready_w) begin
      if (req_in_range) begin
        state_d     = ST_APPLY;
        pend_mult_d = req.req_mult;
        fail_d      = 1'b0;
        lock_lost_d = 1'b0;
        retry_d     = '0;
        clk_ok_d    = 1'b0;
      end else begin
        req_reject_d = 1'b1;
      end
    end

    // Registered outputs are decoded from the next state.
    pll_reset_d = (state_d == ST_APPLY) || (state_d == ST_HOLD);
    busy_d      = !((state_d == ST_IDLE) || (state_d == ST_FAIL));
    fbdsel_d    = mult_to_fbdsel(cur_mult_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_HOLD;
      hold_cnt_q   <= '0;
      to_cnt_q     <= '0;
      settle_cnt_q <= '0;
      retry_q      <= '0;
      pend_mult_q  <= DEF6;
      cur_mult_q   <= DEF6;
      fbdsel_q     <= mult_to_fbdsel(DEF6);
      pll_reset_q  <= 1'b1;
      clk_ok_q     <= 1'b0;
      busy_q       <= 1'b1;
      fail_q       <= 1'b0;
      lock_lost_q  <= 1'b0;
      req_reject_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      to_cnt_q     <= to_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      retry_q      <= retry_d;
      pend_mult_q  <= pend_mult_d;
      cur_mult_q   <= cur_mult_d;
      fbdsel_q     <= fbdsel_d;
      pll_reset_q  <= pll_reset_d;
      clk_ok_q     <= clk_ok_d;
      busy_q       <= busy_d;
      fail_q       <= fail_d;
      lock_lost_q  <= lock_lost_d;
      req_reject_q <= req_reject_d;
    end
  end

  assign req.req_ready  = req_ready_w;
  assign req.req_reject = req_reject_q;
  assign pll_fbdsel     = fbdsel_q;
  assign pll_reset      = pll_reset_q;
  assign clk_ok         = clk_ok_q;
  assign busy           = busy_q;
  assign fail           = fail_q;
  assign lock_lost      = lock_lost_q;
  assign cur_mult       = cur_mult_q;

endmodule

// File: doc/atomik_pll_ctrl.md
# atomik_pll_ctrl

Sequencer for the dynamic feedback divider of the 108 MHz fabric PLL (27 MHz input, input divide 2, output divide 4, clkout = 13.5 MHz × multiplier). Runs on the 27 MHz reference clock, accepts multiplier-change requests and drives the PLL's fbdsel/reset pins. It waits for a qualified lock and reports a clean `clk_ok` to the reset/clock-gating logic of the clkout domain. It also brings the PLL up from power-on with the default multiplier.

## Interface
Parameters:
- DEFAULT_MULT, 8: multiplier applied after reset (108 MHz).
- MULT_MIN, 8: lowest accepted multiplier (VCO ≥ 432 MHz).
- MULT_MAX, 16: highest accepted multiplier.
- RESET_HOLD_CYCLES, 16: clk cycles pll_reset is held high per attempt.
- SETTLE_CYCLES, 256: continuous synchronized-lock cycles required.
- LOCK_TIMEOUT_CYCLES, 65535: cycles in WAIT_LOCK before an attempt fails.
- MAX_RETRIES, 3: attempts per request before FAIL.

Ports:
- clk  in  1  27 MHz reference clock.
- rst_n  in  1  reset: synchronous, active-low.
- req_valid  in  1  multiplier-change request.
- req_mult  in  6  requested multiplier.
- req_ready  out  1  high in IDLE and FAIL only.
- req_reject  out  1  one-cycle pulse: request out of range and dropped.
- pll_fbdsel  out  6  to PLL FBDSEL; encoding 64 − mult (mult 8 → 6'b111000).
- pll_reset  out  1  to PLL RESET, active-high.
- pll_lock  in  1  PLL LOCK, asynchronous to clk.
- clk_ok  out  1  clkout stable at cur_mult.
- busy  out  1  sequence in progress.
- fail  out  1  sticky: last request exhausted retries.
- lock_lost  out  1  sticky: lock dropped while in IDLE; cleared on accepted request.
- cur_mult  out  6  multiplier currently programmed.

## Operation
- States: APPLY, HOLD, WAIT_LOCK, SETTLE, IDLE, FAIL.
- Reset values: state HOLD, pll_reset=1, pll_fbdsel=64−DEFAULT_MULT, cur_mult=DEFAULT_MULT, clk_ok=0, busy=1, req_ready=0, req_reject=0, fail=0, lock_lost=0, counters 0.
- Accept: req_valid && req_ready. If MULT_MIN ≤ req_mult ≤ MULT_MAX → APPLY, clear fail, lock_lost and retry count. Otherwise pulse req_reject; state and outputs unchanged.
- APPLY (1 cycle): pll_reset=1, clk_ok=0, fbdsel still old value. The divider never changes while the PLL runs.
- HOLD: pll_fbdsel and cur_mult take the new value on entry; pll_reset=1 for RESET_HOLD_CYCLES, then → WAIT_LOCK.
- WAIT_LOCK: pll_reset=0. Synchronized lock high → SETTLE. Timeout → retry+1; if retry reaches MAX_RETRIES → FAIL, else → HOLD.
- SETTLE: counts synchronized lock high. Any low sample → WAIT_LOCK with the timeout counter preserved, not restarted. Count reaches SETTLE_CYCLES → IDLE, clk_ok=1, busy=0.
- IDLE: synchronized lock low → clk_ok=0 and lock_lost=1 the same cycle (behaviour continues per Configuration).
- FAIL: pll_reset=0, clk_ok=0, busy=0, fail=1, cur_mult keeps the failed value. Only an accepted request leaves FAIL.
- req_valid outside IDLE/FAIL is ignored, not queued.
- rst_n low in any state: returns to reset values the next edge and restarts bring-up with DEFAULT_MULT.

## Timing
- Lock synchronizer: 2 flops; lock-to-state latency is 2 cycles.
- Accept at edge N: N+1 APPLY (pll_reset=1, clk_ok=0). N+2 HOLD (fbdsel new). pll_reset falls at N+2+RESET_HOLD_CYCLES.
- clk_ok rises exactly SETTLE_CYCLES cycles after the first synchronized-lock-high cycle of an unbroken run.
- All outputs are registered; req_ready is a decode of the registered state.

## Configuration
- ATOMIK_PLL_AUTORELOCK_EN defined: lock loss in IDLE → HOLD with the same cur_mult and retry count 0; the normal retry/FAIL rules apply.
- Not defined: lock loss in IDLE stays in IDLE. clk_ok follows synchronized lock, rising again only after SETTLE_CYCLES of continuous lock. No automatic PLL reset.

## Structure
- Package atomik_pll_pkg holds:
  - the state enum;
  - the mult_to_fbdsel function (64 − mult);
  - the default MULT_MIN/MULT_MAX constants.
- Sub-module atomik_sync2: generic 2-flop synchronizer, used for pll_lock.

## Test plan
- Power-up, lock model asserts 40 cycles after pll_reset falls: pll_reset high 16 cycles, fbdsel=6'b111000, clk_ok at +256 after lock, cur_mult=8.
- Request 12 from IDLE: APPLY with fbdsel still 111000, then 110100 in HOLD. clk_ok low throughout, high after settle, cur_mult=12.
- Request 20 and request 4: req_reject pulses; fbdsel, cur_mult and clk_ok unchanged.
- Lock never asserts: 3 × (16 hold + 65535 wait) cycles → FAIL, fail=1, req_ready=1. A valid request clears fail.
- Lock glitch low for 1 cycle at settle count 200: returns to WAIT_LOCK. clk_ok only after 256 further continuous cycles.
- Lock drop in IDLE: lock_lost=1, clk_ok=0. With ATOMIK_PLL_AUTORELOCK_EN, pll_reset pulses 16 cycles; without it, pll_reset stays 0. Also assert rst_n low mid-HOLD and check reset values next edge.
